// File: rtl/uc_pkg.sv
// Shared opcode map, FSM state encoding and decoded-control payload for the microc control unit.
package uc_pkg;

   localparam int unsigned OPW   = 6;
   localparam int unsigned ALUW  = 3;

   localparam logic [ALUW-1:0] OP_ALU_PFX = 3'b000;
   localparam logic [OPW-1:0]  OP_LOADI   = 6'b001000;
   localparam logic [OPW-1:0]  OP_JMP     = 6'b010000;
   localparam logic [OPW-1:0]  OP_JZ      = 6'b010001;
   localparam logic [OPW-1:0]  OP_JNZ     = 6'b010010;
   localparam logic [OPW-1:0]  OP_CALL    = 6'b010011;
   localparam logic [OPW-1:0]  OP_RET     = 6'b010100;
   localparam logic [OPW-1:0]  OP_JREL    = 6'b010101;
   localparam logic [OPW-1:0]  OP_IN      = 6'b011000;
   localparam logic [OPW-1:0]  OP_OUT     = 6'b011001;
   localparam logic [OPW-1:0]  OP_OUTI    = 6'b011010;
   localparam logic [OPW-1:0]  OP_WAIT    = 6'b011100;
   localparam logic [OPW-1:0]  OP_HALT    = 6'b111111;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Datapath select/enable bundle
   typedef struct packed {
      logic            s_inc;
      logic            s_inm;
      logic            we3;
      logic [ALUW-1:0] op;
      logic            s_subrutina;
      logic            s_ra;
      logic            s_rel;
      logic            s_in;
      logic            s_out;
      logic            out_in;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  alu;
      logic  wait_op;
      logic  halt;
   } dec_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode-to-control table for the RUN state.
// With UC_ERR_EN defined it also flags CALL, RET and undefined opcodes.
module uc_decode
   import uc_pkg::*;
(
   input  logic [OPW-1:0] i_opcode,
   input  logic           i_zflag,
   output dec_t           o_dec_c
`ifdef UC_ERR_EN
   ,
   output logic           o_call_c,
   output logic           o_ret_c,
   output logic           o_illegal_c
`endif
);

   always_comb begin
      o_dec_c            = '0;
      o_dec_c.ctrl.s_inc = 1'b1;
`ifdef UC_ERR_EN
      o_call_c    = 1'b0;
      o_ret_c     = 1'b0;
      o_illegal_c = 1'b0;
`endif
      if (i_opcode[OPW-1:ALUW] == OP_ALU_PFX) begin
         o_dec_c.ctrl.we3 = 1'b1;
         o_dec_c.ctrl.op  = i_opcode[ALUW-1:0];
         o_dec_c.alu      = 1'b1;
      end else begin
         case (i_opcode)
            OP_LOADI: begin
               o_dec_c.ctrl.we3   = 1'b1;
               o_dec_c.ctrl.s_inm = 1'b1;
            end
            OP_JMP:  o_dec_c.ctrl.s_inc = 1'b0;
            OP_JZ:   o_dec_c.ctrl.s_inc = ~i_zflag;
            OP_JNZ:  o_dec_c.ctrl.s_inc = i_zflag;
            OP_CALL: begin
               o_dec_c.ctrl.s_inc       = 1'b0;
               o_dec_c.ctrl.s_subrutina = 1'b1;
`ifdef UC_ERR_EN
               o_call_c = 1'b1;
`endif
            end
            OP_RET: begin
               o_dec_c.ctrl.s_ra = 1'b1;
`ifdef UC_ERR_EN
               o_ret_c = 1'b1;
`endif
            end
            OP_JREL: o_dec_c.ctrl.s_rel = 1'b1;
            OP_IN: begin
               o_dec_c.ctrl.we3  = 1'b1;
               o_dec_c.ctrl.s_in = 1'b1;
            end
            OP_OUT:  o_dec_c.ctrl.s_out = 1'b1;
            OP_OUTI: begin
               o_dec_c.ctrl.s_out  = 1'b1;
               o_dec_c.ctrl.out_in = 1'b1;
            end
            // WAIT and HALT hold the PC on their own (self-addressed) target
            OP_WAIT: begin
               o_dec_c.ctrl.s_inc = 1'b0;
               o_dec_c.wait_op    = 1'b1;
            end
            OP_HALT: begin
               o_dec_c.ctrl.s_inc = 1'b0;
               o_dec_c.halt       = 1'b1;
            end
            default: begin
`ifdef UC_ERR_EN
               o_illegal_c = 1'b1;
`endif
            end
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Sequencer for the microc datapath: RUN/WAIT/HALT FSM, registered Z flag and WAIT counter.
// Optional UC_ERR_EN builds call-depth tracking plus sticky err_stack/err_illegal flags.
module control_unit
   import uc_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 16,
   parameter int unsigned MAX_DEPTH   = 1,
   parameter int unsigned DW          = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  opcode,
   input  logic            z,
   output logic            s_inc,
   output logic            s_inm,
   output logic            we3,
   output logic [ALUW-1:0] op,
   output logic            s_subrutina,
   output logic            s_ra,
   output logic            s_rel,
   output logic            s_in,
   output logic            s_out,
   output logic            out_in,
   output logic            halted,
   output logic            err_stack,
   output logic            err_illegal
);

   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   if (WAIT_CYCLES < 1 || MAX_DEPTH >= (1 << DW)) begin : g_param_chk
      $error("control_unit: WAIT_CYCLES must be >=1 and MAX_DEPTH must fit in DW bits");
   end

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_zflag;
   logic [CW-1:0] r_wait_cnt;
   dec_t          w_dec;
   ctrl_t         w_ctrl;
   logic          w_halted;
   logic          w_run;

   assign w_run = (r_state == ST_RUN);

`ifdef UC_ERR_EN
   logic w_call;
   logic w_ret;
   logic w_illegal;

   uc_decode u_decode (
      .i_opcode    (opcode),
      .i_zflag     (r_zflag),
      .o_dec_c     (w_dec),
      .o_call_c    (w_call),
      .o_ret_c     (w_ret),
      .o_illegal_c (w_illegal)
   );
`else
   uc_decode u_decode (
      .i_opcode (opcode),
      .i_zflag  (r_zflag),
      .o_dec_c  (w_dec)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // Next state and control outputs; WAIT/HALT override the decode table
   always_comb begin
      w_state_nxt = r_state;
      w_ctrl      = '0;
      w_halted    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_ctrl = w_dec.ctrl;
            if (w_dec.wait_op)   w_state_nxt = ST_WAIT;
            else if (w_dec.halt) w_state_nxt = ST_HALT;
         end
         ST_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_ctrl.s_inc = 1'b1;
               w_state_nxt  = ST_RUN;
            end
         end
         ST_HALT: w_halted = 1'b1;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_zflag    <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         if (w_run && w_dec.alu) r_zflag <= z;
         if (w_run && w_dec.wait_op)
            r_wait_cnt <= CW'(WAIT_CYCLES - 1);
         else if (r_state == ST_WAIT && r_wait_cnt != '0)
            r_wait_cnt <= r_wait_cnt - CW'(1);
      end
   end

`ifdef UC_ERR_EN
   logic [DW-1:0] r_depth;
   logic          r_err_stack;
   logic          r_err_illegal;

   // Depth saturates at both ends; an overflow/underflow still executes but latches the error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_depth       <= '0;
         r_err_stack   <= 1'b0;
         r_err_illegal <= 1'b0;
      end else if (w_run) begin
         if (w_call) begin
            if (r_depth == DW'(MAX_DEPTH)) r_err_stack <= 1'b1;
            else                           r_depth     <= r_depth + DW'(1);
         end
         if (w_ret) begin
            if (r_depth == '0) r_err_stack <= 1'b1;
            else               r_depth     <= r_depth - DW'(1);
         end
         if (w_illegal) r_err_illegal <= 1'b1;
      end
   end

   assign err_stack   = reset & r_err_stack;
   assign err_illegal = reset & r_err_illegal;
`else
   assign err_stack   = 1'b0;
   assign err_illegal = 1'b0;
`endif

   // Everything is forced low while reset is held
   assign s_inc       = reset & w_ctrl.s_inc;
   assign s_inm       = reset & w_ctrl.s_inm;
   assign we3         = reset & w_ctrl.we3;
   assign op          = {ALUW{reset}} & w_ctrl.op;
   assign s_subrutina = reset & w_ctrl.s_subrutina;
   assign s_ra        = reset & w_ctrl.s_ra;
   assign s_rel       = reset & w_ctrl.s_rel;
   assign s_in        = reset & w_ctrl.s_in;
   assign s_out       = reset & w_ctrl.s_out;
   assign out_in      = reset & w_ctrl.out_in;
   assign halted      = reset & w_halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_control_unit;

   localparam int unsigned WC  = 4;
   localparam int unsigned MAXD = 1;
`ifdef UC_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'b0;
   logic       z = 1'b0;
   logic       s_inc, s_inm, we3, s_subrutina, s_ra, s_rel, s_in, s_out, out_in;
   logic       halted, err_stack, err_illegal;
   logic [2:0] op;

   control_unit #(.WAIT_CYCLES(WC), .MAX_DEPTH(MAXD), .DW(2)) dut (
      .clk(clk), .reset(rst_n), .opcode(opcode), .z(z),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .op(op),
      .s_subrutina(s_subrutina), .s_ra(s_ra), .s_rel(s_rel),
      .s_in(s_in), .s_out(s_out), .out_in(out_in),
      .halted(halted), .err_stack(err_stack), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   // Bit map: 14 s_inc,13 s_inm,12 we3,11:9 op,8 sub,7 ra,6 rel,5 in,4 out,3 out_in,2 halted,1 err_stack,0 err_illegal
   logic [14:0] act_v;
   assign act_v = {s_inc, s_inm, we3, op, s_subrutina, s_ra, s_rel, s_in, s_out, out_in,
                   halted, err_stack, err_illegal};

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [14:0] smp;

   // Model state
   int   m_wait_left;
   logic m_halted, m_z, m_err_stack, m_err_ill;
   int   m_depth;

   function automatic logic is_defined(input logic [5:0] o);
      return (o[5:3] == 3'b000) || (o inside {6'b001000, 6'b010000, 6'b010001, 6'b010010,
             6'b010011, 6'b010100, 6'b010101, 6'b011000, 6'b011001, 6'b011010,
             6'b011100, 6'b111111});
   endfunction

   task automatic model_reset();
      m_wait_left = 0; m_halted = 1'b0; m_z = 1'b0;
      m_err_stack = 1'b0; m_err_ill = 1'b0; m_depth = 0;
   endtask

   function automatic logic [14:0] model_out(input logic [5:0] o);
      logic [14:0] e;
      e = '0;
      if (!rst_n) return e;
      if (m_halted) e[2] = 1'b1;
      else if (m_wait_left > 0) e[14] = (m_wait_left == 1);
      else begin
         e[14] = 1'b1;
         if (o[5:3] == 3'b000) begin e[12] = 1'b1; e[11:9] = o[2:0]; end
         else case (o)
            6'b001000: begin e[12] = 1'b1; e[13] = 1'b1; end
            6'b010000: e[14] = 1'b0;
            6'b010001: e[14] = ~m_z;
            6'b010010: e[14] = m_z;
            6'b010011: begin e[14] = 1'b0; e[8] = 1'b1; end
            6'b010100: e[7] = 1'b1;
            6'b010101: e[6] = 1'b1;
            6'b011000: begin e[12] = 1'b1; e[5] = 1'b1; end
            6'b011001: e[4] = 1'b1;
            6'b011010: begin e[4] = 1'b1; e[3] = 1'b1; end
            6'b011100, 6'b111111: e[14] = 1'b0;
            default: ;
         endcase
      end
      e[1] = ERR_EN & m_err_stack;
      e[0] = ERR_EN & m_err_ill;
      return e;
   endfunction

   task automatic model_edge(input logic [5:0] o, input logic zv);
      if (m_halted) return;
      if (m_wait_left > 0) begin m_wait_left--; return; end
      if (o[5:3] == 3'b000) m_z = zv;
      if (o == 6'b010011) begin
         if (m_depth == MAXD) m_err_stack = 1'b1; else m_depth++;
      end
      if (o == 6'b010100) begin
         if (m_depth == 0) m_err_stack = 1'b1; else m_depth--;
      end
      if (o == 6'b011100) m_wait_left = WC;
      if (o == 6'b111111) m_halted = 1'b1;
      if (!is_defined(o)) m_err_ill = 1'b1;
   endtask

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d act=%b exp=%b", name, cyc, act, exp);
   endtask

   // One clock: drive, compare against the model mid-cycle, advance model at the edge
   task automatic step(input logic rv, input logic [5:0] o, input logic zv);
      rst_n = rv; opcode = o; z = zv;
      if (!rv) model_reset();
      #3;
      smp = act_v;
      chk($sformatf("ctrl opc=%b", o), smp, model_out(o));
      @(posedge clk);
      if (rv) model_edge(o, zv);
      #1;
      cyc++;
   endtask

   logic [4:0] wait_pat;

   initial begin
      model_reset();
      // Reset held: everything quiet even with LOADI presented
      step(1'b0, 6'b001000, 1'b0);
      chk("reset_quiet", smp, 15'd0);
      step(1'b0, 6'b001000, 1'b1);
      step(1'b1, 6'b001000, 1'b0);
      chk("loadi_after_reset", {12'd0, smp[14:12]}, 15'b111);

      // JZ/JNZ use the registered flag, not live z
      step(1'b1, 6'b000010, 1'b1);
      step(1'b1, 6'b010001, 1'b0);
      chk("jz_taken", {14'd0, smp[14]}, 15'd0);
      step(1'b1, 6'b000010, 1'b0);
      step(1'b1, 6'b010001, 1'b1);
      chk("jz_not_taken_live_z", {14'd0, smp[14]}, 15'd1);
      step(1'b1, 6'b010010, 1'b1);
      chk("jnz_taken", {14'd0, smp[14]}, 15'd0);
      step(1'b1, 6'b000111, 1'b1);
      step(1'b1, 6'b001000, 1'b0);
      step(1'b1, 6'b010010, 1'b0);
      chk("jnz_flag_kept_by_loadi", {14'd0, smp[14]}, 15'd1);

      // All ALU ops and the remaining defined opcodes
      for (int i = 0; i < 8; i++) step(1'b1, 6'(i), 1'(i % 2));
      step(1'b1, 6'b010000, 1'b0);
      step(1'b1, 6'b010101, 1'b0);
      step(1'b1, 6'b011000, 1'b0);
      chk("in_decode", smp & 15'b111_1111_1111_1000, 15'b101_0000_0010_0000);
      step(1'b1, 6'b011001, 1'b0);
      step(1'b1, 6'b011010, 1'b0);
      chk("outi_decode", smp & 15'b111_1111_1111_1000, 15'b100_0000_0001_1000);

      // WAIT: four held cycles, then advance
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 6'b011100, 1'b0);
         wait_pat[4-i] = smp[14];
      end
      chk("wait_pattern", {10'd0, wait_pat}, 15'b00001);
      step(1'b1, 6'b001000, 1'b0);
      chk("run_after_wait", {12'd0, smp[14:12]}, 15'b111);

      // Call depth: overflow then underflow
      step(1'b1, 6'b010011, 1'b0);
      chk("call1_sub", {14'd0, smp[8]}, 15'd1);
      step(1'b1, 6'b010011, 1'b0);
      chk("call2_sub", {14'd0, smp[8]}, 15'd1);
      step(1'b1, 6'b010100, 1'b0);
      chk("err_stack_rise", {14'd0, smp[1]}, {14'd0, ERR_EN});
      step(1'b1, 6'b010100, 1'b0);
      step(1'b1, 6'b010100, 1'b0);
      step(1'b1, 6'b001000, 1'b0);
      chk("err_stack_sticky", {14'd0, smp[1]}, {14'd0, ERR_EN});

      // Undefined opcode behaves as NOP and flags
      step(1'b1, 6'b100000, 1'b0);
      chk("illegal_nop", smp & 15'b111_1111_1111_1000, 15'b100_0000_0000_0000);
      step(1'b1, 6'b001001, 1'b0);
      chk("err_illegal_rise", {14'd0, smp[0]}, {14'd0, ERR_EN});

      // Reset mid-WAIT
      step(1'b1, 6'b011100, 1'b0);
      step(1'b1, 6'b011100, 1'b0);
      step(1'b0, 6'b011100, 1'b0);
      step(1'b1, 6'b001000, 1'b0);
      chk("run_after_wait_reset", smp, 15'b111_0000_0000_0000);

      // HALT ignores everything until reset
      step(1'b1, 6'b111111, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
         chk("halt_hold", {12'd0, smp[14], smp[12], smp[2]}, 15'b001);
      end
      step(1'b0, 6'b000001, 1'b0);
      step(1'b1, 6'b001000, 1'b0);
      chk("halt_cleared", {14'd0, smp[2]}, 15'd0);
      step(1'b1, 6'b010001, 1'b1);
      chk("zflag_cleared_by_reset", {14'd0, smp[14]}, 15'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequential control unit for the `microc` datapath; the other end of the datapath's control interface.
- Consumes `opcode` (instruction bits [5:0]) and the ALU zero flag `z`.
- Drives every datapath select/enable: PC mux, immediate mux, register write, subroutine, relative jump, I/O.
- Adds registered state the datapath lacks: a Z flag, call-depth tracking, a multi-cycle WAIT, and HALT.

Parameters:
- WAIT_CYCLES, 16, number of cycles a WAIT instruction holds the PC (≥1).
- MAX_DEPTH, 1, call nesting supported by the datapath return register.
- DW, 2, width of the depth counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  current instruction opcode.
- z  in  1  combinational ALU zero from the datapath.
- s_inc  out  1  1 = PC+1, 0 = absolute target (instr[15:6]).
- s_inm  out  1  1 = immediate to register write.
- we3  out  1  register file write enable.
- op  out  3  ALU operation.
- s_subrutina  out  1  load return register with PC+1.
- s_ra  out  1  PC from return register.
- s_rel  out  1  PC from relative adder.
- s_in  out  1  write data from input port.
- s_out  out  1  output port write strobe.
- out_in  out  1  output source: 0 = RD2, 1 = immediate.
- halted  out  1  HALT state reached.
- err_stack  out  1  sticky call/return depth error.
- err_illegal  out  1  sticky undefined-opcode flag.

Behaviour:
- States: RUN, WAIT, HALT. Reset to RUN; zflag=0, depth=0, wait counter=0, both error flags=0.
- Control outputs are combinational from (state, opcode, zflag).
- While `reset` is low, all outputs are 0.
- Opcode decoding in RUN:
  - 000ooo ALU: we3=1, op=ooo, s_inc=1; zflag<=z at the edge.
  - 001000 LOADI: we3=1, s_inm=1, s_inc=1.
  - 010000 JMP: s_inc=0.
  - 010001 JZ: s_inc=~zflag.
  - 010010 JNZ: s_inc=zflag.
  - 010011 CALL: s_inc=0, s_subrutina=1; depth++.
  - 010100 RET: s_ra=1, s_inc=1; depth--.
  - 010101 JREL: s_rel=1, s_inc=1.
  - 011000 IN: we3=1, s_in=1, s_inc=1.
  - 011001 OUT: s_out=1, out_in=0, s_inc=1.
  - 011010 OUTI: s_out=1, out_in=1, s_inc=1.
  - 011100 WAIT: s_inc=0 (the assembler encodes the instruction's own address in [15:6]); counter<=WAIT_CYCLES-1; go to WAIT.
  - 111111 HALT: s_inc=0 (self address); go to HALT.
  - Any other opcode: NOP (s_inc=1, no write).
- Only ALU ops update zflag. JZ/JNZ use the registered zflag, never the live `z`.
- WAIT state:
  - s_inc=0, counter decrements each cycle, all writes 0.
  - When counter==0: s_inc=1 and return to RUN.
  - Total WAIT instruction latency = WAIT_CYCLES+1 cycles.
- HALT state: s_inc=0 forever, halted=1; only reset exits.
- Boundaries:
  - CALL when depth==MAX_DEPTH: still executes (return register overwritten); depth saturates; err_stack<=1.
  - RET when depth==0: executes; depth stays 0; err_stack<=1.
  - Reset mid-WAIT or in HALT: immediate return to RUN with cleared state.
  - Error flags are sticky until reset.

Optional Feature:
- UC_ERR_EN defined: depth counter, err_stack and err_illegal logic are built.
- UC_ERR_EN undefined: that logic is removed, err_stack and err_illegal are tied to 0, and CALL/RET decode is unchanged.

Decomposition:
- Package `uc_pkg`: opcode localparams (OP_ALU_PFX, OP_LOADI, OP_JMP, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_JREL, OP_IN, OP_OUT, OP_OUTI, OP_WAIT, OP_HALT) and state encoding (ST_RUN, ST_WAIT, ST_HALT).
- One sub-module: `uc_decode`, the purely combinational opcode-to-control table. Sequencer, zflag, depth and wait counter stay in `control_unit`.

Test Plan:
- Reset low, then high with opcode=001000 -> all outputs 0 during reset; next cycle we3=1, s_inm=1, s_inc=1.
- ALU 000010 with z=1, then JZ -> JZ drives s_inc=0. Then ALU with z=0 followed by JZ -> s_inc=1, even if live z=1 during JZ.
- WAIT with WAIT_CYCLES=4 -> s_inc=0 for exactly 4 cycles, s_inc=1 on the 5th cycle, then RUN.
- CALL, CALL, RET, RET, RET (MAX_DEPTH=1) -> s_subrutina=1 on both CALLs; err_stack rises after the 2nd CALL and stays 1.
- Opcode 100000 -> NOP with s_inc=1 and err_illegal=1. With UC_ERR_EN undefined, err_illegal stays 0.
- HALT, then random opcodes for 20 cycles -> halted=1, s_inc=0, we3=0 throughout; reset pulse mid-HALT -> halted=0.
